hwlp_rf: RTL and testbench

Hardware-loop register file and IV sequencer for the Mage access path. Walks a nest of up to N_LP affine loops, one iteration per enabled cycle. Pushes each IV tuple into an HWLP_RF_SIZE-deep shift-register history, together with its valid, per-loop end-condition and end-of-nest flags. The history feeds the HWLP reorder unit, which selects per-AGE entries; entry k is the tuple pushed k enabled cycles ago.

---
 rtl/hwlp_rf.sv | 149 ++++++++++++++
 tb/tb_hwlp_rf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hwlp_rf.sv
// Hardware-loop register file: walks an affine loop nest and keeps a shift-register history of IV tuples.
// Optional HWLP_RF_ITER_CNT_EN adds a saturating 32-bit RUN-push counter on iter_cnt_o.
module hwlp_rf_lp #(
    parameter int NBIT = 8
) (
    input  logic            active,
    input  logic            carry,
    input  logic [NBIT-1:0] iv,
    input  logic [NBIT-1:0] init,
    input  logic [NBIT-1:0] lend,
    input  logic [NBIT-1:0] step,
    output logic            last,
    output logic [NBIT-1:0] iv_nxt
);
    logic [NBIT:0] sum;

    // One extra bit so the bound compare never sees a wrapped sum
    assign sum    = {1'b0, iv} + {1'b0, step};
    assign last   = !active || (step == '0) || (sum > {1'b0, lend});
    assign iv_nxt = !carry ? iv : (last ? init : sum[NBIT-1:0]);
endmodule

module hwlp_rf #(
    parameter int N_LP         = 4,
    parameter int NBIT_LP_IV   = 8,
    parameter int HWLP_RF_SIZE = 8,
    localparam int NLW = $clog2(N_LP+1),
    localparam int CW  = $clog2(HWLP_RF_SIZE+1)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_n_i,
    input  logic                                             start_i,
    input  logic                                             clear_i,
    input  logic                                             en_i,
    input  logic [NLW-1:0]                                   reg_n_lp_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                  reg_lp_init_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                  reg_lp_end_i,
    input  logic [N_LP-1:0][NBIT_LP_IV-1:0]                  reg_lp_step_i,
    output logic [HWLP_RF_SIZE-1:0][N_LP-1:0][NBIT_LP_IV-1:0] hwlp_rf_o,
    output logic [HWLP_RF_SIZE-1:0]                          hwlp_valid_o,
    output logic [HWLP_RF_SIZE-1:0][N_LP-1:0]                hwlp_end_condition_o,
    output logic [HWLP_RF_SIZE-1:0]                          end_lp_o,
    output logic                                             busy_o,
    output logic                                             done_o
`ifdef HWLP_RF_ITER_CNT_EN
    ,
    output logic [31:0]                                      iter_cnt_o
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]                            state;
    logic [CW-1:0]                         cnt;
    logic [N_LP-1:0][NBIT_LP_IV-1:0]       iv, iv_nxt;
    logic [N_LP-1:0]                       last;
    logic [N_LP:0]                         carry;

    // carry[k] = all inner loops are on their last iteration, so loop k steps
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < N_LP; k++) begin : g_lp
        assign carry[k+1] = carry[k] & last[k];
        hwlp_rf_lp #(.NBIT(NBIT_LP_IV)) u_lp (
            .active (NLW'(k) < reg_n_lp_i),
            .carry  (carry[k]),
            .iv     (iv[k]),
            .init   (reg_lp_init_i[k]),
            .lend   (reg_lp_end_i[k]),
            .step   (reg_lp_step_i[k]),
            .last   (last[k]),
            .iv_nxt (iv_nxt[k])
        );
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state                <= IDLE;
            cnt                  <= '0;
            iv                   <= '0;
            hwlp_rf_o            <= '0;
            hwlp_valid_o         <= '0;
            hwlp_end_condition_o <= '0;
            end_lp_o             <= '0;
            done_o               <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                // Flush marks only; data entries are left as they are
                state                <= IDLE;
                cnt                  <= '0;
                hwlp_valid_o         <= '0;
                hwlp_end_condition_o <= '0;
                end_lp_o             <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            iv    <= reg_lp_init_i;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (en_i) begin
                            hwlp_rf_o            <= {hwlp_rf_o[HWLP_RF_SIZE-2:0], iv};
                            hwlp_valid_o         <= {hwlp_valid_o[HWLP_RF_SIZE-2:0], 1'b1};
                            hwlp_end_condition_o <= {hwlp_end_condition_o[HWLP_RF_SIZE-2:0], carry[N_LP:1]};
                            end_lp_o             <= {end_lp_o[HWLP_RF_SIZE-2:0], carry[N_LP]};
                            iv                   <= iv_nxt;
                            if (carry[N_LP]) begin
                                state <= DRAIN;
                                cnt   <= CW'(HWLP_RF_SIZE);
                            end
                        end
                    end
                    DRAIN: begin
                        if (en_i) begin
                            hwlp_rf_o            <= {hwlp_rf_o[HWLP_RF_SIZE-2:0], {(N_LP*NBIT_LP_IV){1'b0}}};
                            hwlp_valid_o         <= {hwlp_valid_o[HWLP_RF_SIZE-2:0], 1'b0};
                            hwlp_end_condition_o <= {hwlp_end_condition_o[HWLP_RF_SIZE-2:0], {N_LP{1'b0}}};
                            end_lp_o             <= {end_lp_o[HWLP_RF_SIZE-2:0], 1'b0};
                            cnt                  <= cnt - 1'b1;
                            if (cnt == CW'(1)) begin
                                done_o <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef HWLP_RF_ITER_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            iter_cnt_o <= '0;
        end else if (clear_i || (state == IDLE && start_i)) begin
            iter_cnt_o <= '0;
        end else if (state == RUN && en_i && iter_cnt_o != 32'hFFFF_FFFF) begin
            iter_cnt_o <= iter_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hwlp_rf.sv
// Directed bench for hwlp_rf: single/nested loops, overflow guard, stalls, clear and async reset.
module tb_hwlp_rf;
    localparam int N_LP = 4;
    localparam int NB   = 8;
    localparam int SZ   = 8;

    logic clk = 1'b0;
    logic rst_n, start, clear, en;
    logic [2:0]                       n_lp;
    logic [N_LP-1:0][NB-1:0]          init, lend, step_v;
    logic [SZ-1:0][N_LP-1:0][NB-1:0]  rf;
    logic [SZ-1:0]                    valid;
    logic [SZ-1:0][N_LP-1:0]          endc;
    logic [SZ-1:0]                    end_lp;
    logic                             busy, done;
`ifdef HWLP_RF_ITER_CNT_EN
    logic [31:0]                      iter_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hwlp_rf #(.N_LP(N_LP), .NBIT_LP_IV(NB), .HWLP_RF_SIZE(SZ)) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .start_i              (start),
        .clear_i              (clear),
        .en_i                 (en),
        .reg_n_lp_i           (n_lp),
        .reg_lp_init_i        (init),
        .reg_lp_end_i         (lend),
        .reg_lp_step_i        (step_v),
        .hwlp_rf_o            (rf),
        .hwlp_valid_o         (valid),
        .hwlp_end_condition_o (endc),
        .end_lp_o             (end_lp),
        .busy_o               (busy),
        .done_o               (done)
`ifdef HWLP_RF_ITER_CNT_EN
        ,
        .iter_cnt_o           (iter_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic cfg1(input logic [NB-1:0] i0, input logic [NB-1:0] e0, input logic [NB-1:0] s0);
        n_lp = 3'd1;
        init = '0; lend = '0; step_v = '0;
        init[0] = i0; lend[0] = e0; step_v[0] = s0;
    endtask

    initial begin
        logic [NB-1:0] e0 [6];
        logic [NB-1:0] e1 [6];
        int dn;
        e0 = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        e1 = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; en = 1'b0;
        cfg1(8'd0, 8'd3, 8'd1);
        #12;
        chk("rst_rf", 64'(rf[0]) | 64'(rf[SZ-1]), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_endc", 64'(endc), 64'd0);
        chk("rst_end", 64'(end_lp), 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        rst_n = 1'b1;
        tick();

        // single loop 0..3
        start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_valid_pre", 64'(valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_iv", 64'(rf[0][0]), 64'(i));
            chk("t1_valid0", 64'(valid[0]), 64'd1);
            chk("t1_endc", 64'(endc[0]), (i == 3) ? 64'hF : 64'd0);
            chk("t1_end", 64'(end_lp[0]), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("t1_valid_all", 64'(valid), 64'h0F);
        chk("t1_hist3", 64'(rf[3][0]), 64'd0);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("t1_no_done", {62'd0, done, busy}, 64'd1);
        end
        tick();
        chk("t1_done", {62'd0, done, busy}, 64'd2);
        chk("t1_valid_post", 64'(valid), 64'd0);
        tick();
        chk("t1_done_pulse", 64'(done), 64'd0);

        // two nested loops
        n_lp = 3'd2;
        init = '0; lend = '0; step_v = '0;
        lend[0] = 8'd1; lend[1] = 8'd2; step_v[0] = 8'd1; step_v[1] = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_l0", 64'(rf[0][0]), 64'(e0[i]));
            chk("t2_l1", 64'(rf[0][1]), 64'(e1[i]));
            chk("t2_endc", 64'(endc[0]), (i == 5) ? 64'hF : ((e0[i] == 8'd1) ? 64'd1 : 64'd0));
            chk("t2_end", 64'(end_lp[0]), (i == 5) ? 64'd1 : 64'd0);
        end
        chk("t2_hist5", 64'(rf[5]), 64'd0);
        chk("t2_hist2", 64'(rf[2][1]), 64'd1);
        chk("t2_valid", 64'(valid), 64'h3F);
        wait_done("t2_done", 20);
        tick();

        // overflow guard: 250, 254 then stop without wrapping
        cfg1(8'd250, 8'd255, 8'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t3_first", {55'd0, end_lp[0], rf[0][0]}, 64'd250);
        tick();
        chk("t3_last", {55'd0, end_lp[0], rf[0][0]}, 64'h1FE);
        chk("t3_state", 64'(busy), 64'd1);
        wait_done("t3_done", 20);
        tick();

        // step 0: single iteration
        cfg1(8'd7, 8'd9, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t3_step0", {55'd0, end_lp[0], rf[0][0]}, 64'h107);
        tick();
        chk("t3_step0_bubble", {62'd0, valid[1:0]}, 64'd2);
        wait_done("t3_step0_done", 20);
        tick();

        // stalls in RUN and DRAIN
        cfg1(8'd0, 8'd3, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick(); tick(); tick();
        chk("t4_run_frz", {40'd0, valid, rf[1][0], rf[0][0]}, {40'd0, 8'h03, 8'd0, 8'd1});
        en = 1'b1;
        tick();
        chk("t4_iv2", 64'(rf[0][0]), 64'd2);
        tick();
        chk("t4_iv3", {55'd0, end_lp[0], rf[0][0]}, 64'h103);
        tick(); tick(); tick();
        en = 1'b0;
        tick(); tick(); tick();
        chk("t4_drn_frz", {48'd0, valid, rf[3][0]}, {48'd0, 8'h78, 8'd3});
        chk("t4_drn_busy", {62'd0, done, busy}, 64'd1);
        en = 1'b1;
        dn = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            dn += int'(done);
        end
        chk("t4_no_early_done", 64'(dn), 64'd0);
        tick();
        chk("t4_done", {54'd0, valid, busy, done}, 64'd1);
        tick();

        // clear mid-RUN with 5 valid entries
        cfg1(8'd0, 8'd20, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5; j++) tick();
        chk("t5_valid5", 64'(valid), 64'h1F);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_cleared", {47'd0, valid, endc[0], end_lp[0], busy, done}, 64'd0);
        chk("t5_data_kept", 64'(rf[0][0]), 64'd4);
        dn = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            dn += int'(done) + int'(busy);
        end
        chk("t5_idle_quiet", 64'(dn), 64'd0);
        // clear beats start in IDLE
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        chk("t5_clr_wins", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t5_restart", {55'd0, valid[0], rf[0][0]}, 64'h100);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // async reset mid-DRAIN
        cfg1(8'd0, 8'd3, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 7; j++) tick();
        chk("t6_in_drain", {55'd0, busy, valid}, 64'h178);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst", {46'd0, valid, end_lp, busy, done}, 64'd0);
        chk("t6_async_rf", 64'(rf[3]) | 64'(endc), 64'd0);
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_clean_first", {55'd0, valid[0], rf[0][0]}, 64'h100);
        wait_done("t6_done", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
